// File: rtl/line_clear_engine.sv
// Row-compaction engine for the 12x12 landed-block board; scans bottom-up, drops full rows.
// Optional running score port enabled with `define LINE_CLEAR_SCORE_EN.
module line_clear_engine #(
    parameter int COLS  = 12,
    parameter int ROWS  = 12,
    parameter int CNT_W = 4,
    localparam int BW   = COLS * ROWS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [BW-1:0]   board_in,
    output logic            busy,
    output logic            done,
    output logic [BW-1:0]   board_out,
    output logic [CNT_W-1:0] lines,
    output logic [ROWS-1:0] full_rows
`ifdef LINE_CLEAR_SCORE_EN
    ,
    output logic [15:0]     score
`endif
);

    localparam int IW = $clog2(ROWS);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t           state_q;
    logic [BW-1:0]    snap_q;
    logic [BW-1:0]    buf_q;
    logic [BW-1:0]    buf_d;
    logic [IW-1:0]    rd_q;
    logic [IW-1:0]    wr_q;
    logic [IW-1:0]    wr_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [ROWS-1:0]  mask_q;
    logic [ROWS-1:0]  mask_d;
    logic             busy_q;
    logic             done_q;
    logic [BW-1:0]    board_out_q;
    logic [CNT_W-1:0] lines_q;
    logic [ROWS-1:0]  full_rows_q;
    logic [COLS-1:0]  row_rd;
    logic             row_full;

    assign row_rd   = snap_q[int'(rd_q)*COLS +: COLS];
    assign row_full = &row_rd;

    // Next-state of the working set for the row currently under rd_q.
    always_comb begin
        buf_d  = buf_q;
        wr_d   = wr_q;
        cnt_d  = cnt_q;
        mask_d = mask_q;
        if (row_full) begin
            mask_d[rd_q] = 1'b1;
            cnt_d        = cnt_q + CNT_W'(1);
        end else begin
            buf_d[int'(wr_q)*COLS +: COLS] = row_rd;
            wr_d = wr_q - IW'(1);
        end
    end

`ifdef LINE_CLEAR_SCORE_EN
    logic [15:0] score_q;

    function automatic logic [15:0] score_add(
        input logic [15:0]      s,
        input logic [CNT_W-1:0] n
    );
        logic [3:0]  inc;
        logic [16:0] sum;
        unique case (1'b1)
            (n == CNT_W'(0)): inc = 4'd0;
            (n == CNT_W'(1)): inc = 4'd1;
            (n == CNT_W'(2)): inc = 4'd3;
            (n == CNT_W'(3)): inc = 4'd5;
            default:          inc = 4'd8;
        endcase
        sum = {1'b0, s} + 17'(inc);
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    assign score = score_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            snap_q      <= '0;
            buf_q       <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            cnt_q       <= '0;
            mask_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            board_out_q <= '0;
            lines_q     <= '0;
            full_rows_q <= '0;
`ifdef LINE_CLEAR_SCORE_EN
            score_q     <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        snap_q  <= board_in;
                        buf_q   <= '0;
                        rd_q    <= IW'(ROWS - 1);
                        wr_q    <= IW'(ROWS - 1);
                        cnt_q   <= '0;
                        mask_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    buf_q  <= buf_d;
                    wr_q   <= wr_d;
                    cnt_q  <= cnt_d;
                    mask_q <= mask_d;
                    rd_q   <= rd_q - IW'(1);
                    // Publish on the final row so results appear with done.
                    if (rd_q == '0) begin
                        state_q     <= DONE;
                        done_q      <= 1'b1;
                        board_out_q <= buf_d;
                        lines_q     <= cnt_d;
                        full_rows_q <= mask_d;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
`ifdef LINE_CLEAR_SCORE_EN
                    score_q <= score_add(score_q, lines_q);
`endif
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign board_out = board_out_q;
    assign lines     = lines_q;
    assign full_rows = full_rows_q;

endmodule

// File: tb/tb_line_clear_engine.sv
// Bench for line_clear_engine: queue-based board model, per-cycle compare, directed passes.
// Score checks compile in when LINE_CLEAR_SCORE_EN is defined.
module tb_line_clear_engine;

    localparam int COLS = 12;
    localparam int ROWS = 12;
    localparam int BW   = COLS * ROWS;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [BW-1:0]   board_in;
    logic            busy;
    logic            done;
    logic [BW-1:0]   board_out;
    logic [3:0]      lines;
    logic [ROWS-1:0] full_rows;
`ifdef LINE_CLEAR_SCORE_EN
    logic [15:0]     score;
`endif

    always #5 clk = ~clk;

    line_clear_engine dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .board_in  (board_in),
        .busy      (busy),
        .done      (done),
        .board_out (board_out),
        .lines     (lines),
`ifdef LINE_CLEAR_SCORE_EN
        .full_rows (full_rows),
        .score     (score)
`else
        .full_rows (full_rows)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [BW-1:0] act,
                       input logic [BW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [BW-1:0]   o;
        logic [3:0]      n;
        logic [ROWS-1:0] m;
    } res_t;

    // Full rows are dropped; survivors are stacked from the bottom up.
    function automatic res_t model(input logic [BW-1:0] b);
        res_t            r;
        logic [COLS-1:0] kept[$];
        logic [COLS-1:0] row;
        r = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            row = b[i*COLS +: COLS];
            if (row == '1) begin
                r.m[i] = 1'b1;
                r.n    = r.n + 4'd1;
            end else begin
                kept.push_back(row);
            end
        end
        foreach (kept[j]) r.o[(ROWS-1-j)*COLS +: COLS] = kept[j];
        return r;
    endfunction

    function automatic logic [15:0] score_next(input logic [15:0] s,
                                               input logic [3:0] n);
        int t;
        int v;
        if (n == 4'd0) t = 0;
        else if (n == 4'd1) t = 1;
        else if (n == 4'd2) t = 3;
        else if (n == 4'd3) t = 5;
        else t = 8;
        v = int'(s) + t;
        return (v > 65535) ? 16'hFFFF : 16'(v);
    endfunction

    function automatic logic [BW-1:0] set_row(input logic [BW-1:0] b,
                                              input int r,
                                              input logic [COLS-1:0] v);
        logic [BW-1:0] x;
        x = b;
        x[r*COLS +: COLS] = v;
        return x;
    endfunction

    bit              mon_en  = 1'b0;
    bit              m_busy  = 1'b0;
    bit              m_done  = 1'b0;
    int              m_left  = 0;
    logic [BW-1:0]   m_out   = '0;
    logic [3:0]      m_lines = '0;
    logic [ROWS-1:0] m_mask  = '0;
    logic [15:0]     m_score = '0;
    res_t            p       = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_left  <= 0;
            m_out   <= '0;
            m_lines <= '0;
            m_mask  <= '0;
            m_score <= '0;
        end else if (m_done) begin
            m_done  <= 1'b0;
            m_busy  <= 1'b0;
            m_score <= score_next(m_score, m_lines);
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done  <= 1'b1;
                m_out   <= p.o;
                m_lines <= p.n;
                m_mask  <= p.m;
            end
        end else if (start) begin
            m_busy <= 1'b1;
            m_left <= ROWS;
            p      <= model(board_in);
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon_busy", BW'(busy), BW'(m_busy));
            chk("mon_done", BW'(done), BW'(m_done));
            chk("mon_board_out", board_out, m_out);
            chk("mon_lines", BW'(lines), BW'(m_lines));
            chk("mon_full_rows", BW'(full_rows), BW'(m_mask));
`ifdef LINE_CLEAR_SCORE_EN
            chk("mon_score", BW'(score), BW'(m_score));
`endif
        end
    end

    task automatic run_pass(input logic [BW-1:0] b, output int lat);
        lat      = -1;
        board_in = b;
        start    = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (done) begin
                lat = k + 1;
                break;
            end
        end
        chk("pass_done_seen", BW'(lat > 0), BW'(1));
    endtask

    logic [BW-1:0] b;
    logic [BW-1:0] e;
    int            lat;
    int            dn;

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        board_in = '0;
        @(negedge clk);
        @(negedge clk);
        mon_en = 1'b1;
        chk("rst_busy", BW'(busy), BW'(0));
        chk("rst_done", BW'(done), BW'(0));
        chk("rst_board_out", board_out, '0);
        chk("rst_lines", BW'(lines), BW'(0));
        chk("rst_full_rows", BW'(full_rows), BW'(0));
        rst = 1'b0;
        @(negedge clk);

        run_pass({12'hFFF, 132'b0}, lat);
        chk("bottom_latency", BW'(lat), BW'(13));
        chk("bottom_board_out", board_out, '0);
        chk("bottom_lines", BW'(lines), BW'(1));
        chk("bottom_full_rows", BW'(full_rows), BW'(12'h800));
        @(negedge clk);
`ifdef LINE_CLEAR_SCORE_EN
        chk("score_1", BW'(score), BW'(1));
`endif

        b = '0;
        b = set_row(b, 11, 12'hFFF);
        b = set_row(b, 9, 12'hFFF);
        b = set_row(b, 10, 12'h001);
        b = set_row(b, 8, 12'h0F0);
        e = '0;
        e = set_row(e, 11, 12'h001);
        e = set_row(e, 10, 12'h0F0);
        run_pass(b, lat);
        chk("two_board_out", board_out, e);
        chk("two_lines", BW'(lines), BW'(2));
        chk("two_full_rows", BW'(full_rows), BW'(12'hA00));
        @(negedge clk);
`ifdef LINE_CLEAR_SCORE_EN
        chk("score_4", BW'(score), BW'(4));
`endif

        run_pass({{48{1'b1}}, 96'b0}, lat);
        chk("four_board_out", board_out, '0);
        chk("four_lines", BW'(lines), BW'(4));
        chk("four_full_rows", BW'(full_rows), BW'(12'hF00));
        @(negedge clk);
`ifdef LINE_CLEAR_SCORE_EN
        chk("score_12", BW'(score), BW'(12));
`endif

        run_pass('0, lat);
        chk("empty_board_out", board_out, '0);
        chk("empty_lines", BW'(lines), BW'(0));
        chk("empty_full_rows", BW'(full_rows), BW'(0));
        @(negedge clk);

        run_pass('1, lat);
        chk("ones_board_out", board_out, '0);
        chk("ones_lines", BW'(lines), BW'(12));
        chk("ones_full_rows", BW'(full_rows), BW'(12'hFFF));
        @(negedge clk);

        b = '0;
        for (int r = 0; r < ROWS; r++) b = set_row(b, r, 12'h5A5 ^ 12'(r));
        run_pass(b, lat);
        chk("keep_board_out", board_out, b);
        chk("keep_lines", BW'(lines), BW'(0));
        @(negedge clk);

        b = '0;
        b = set_row(b, 11, 12'hFFF);
        b = set_row(b, 6, 12'hFFF);
        b = set_row(b, 7, 12'h00F);
        b = set_row(b, 5, 12'h0F0);
        b = set_row(b, 0, 12'h801);
        e = '0;
        e = set_row(e, 8, 12'h00F);
        e = set_row(e, 7, 12'h0F0);
        e = set_row(e, 2, 12'h801);
        run_pass(b, lat);
        chk("gap_board_out", board_out, e);
        chk("gap_lines", BW'(lines), BW'(2));
        chk("gap_full_rows", BW'(full_rows), BW'(12'h840));
        @(negedge clk);

        b = set_row({12'hFFF, 132'b0}, 3, 12'h123);
        e = set_row('0, 4, 12'h123);
        board_in = b;
        start    = 1'b1;
        lat      = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 2) board_in = '1;
            if (done) begin
                lat = k + 1;
                break;
            end
        end
        chk("held_latency", BW'(lat), BW'(13));
        chk("held_board_out", board_out, e);
        chk("held_lines", BW'(lines), BW'(1));
        chk("held_full_rows", BW'(full_rows), BW'(12'h800));
        @(negedge clk);
        chk("held_idle_busy", BW'(busy), BW'(0));
        chk("held_idle_done", BW'(done), BW'(0));
        @(negedge clk);
        chk("held_reaccept_busy", BW'(busy), BW'(1));
        start = 1'b0;
        lat   = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
        chk("held_second_done_seen", BW'(lat >= 0), BW'(1));
        chk("held_second_lines", BW'(lines), BW'(12));
        @(negedge clk);

        board_in = {12'hFFF, 132'b0};
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", BW'(busy), BW'(0));
        chk("midrst_board_out", board_out, '0);
        chk("midrst_lines", BW'(lines), BW'(0));
        dn = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("midrst_no_done", BW'(dn), BW'(0));

`ifdef LINE_CLEAR_SCORE_EN
        board_in = {{48{1'b1}}, 96'b0};
        start    = 1'b1;
        dn       = 0;
        for (int k = 0; k < 8192 * 15; k++) begin
            @(negedge clk);
            if (done) dn++;
            if (dn == 8192) break;
        end
        start = 1'b0;
        chk("sat_passes", BW'(dn), BW'(8192));
        @(negedge clk);
        @(negedge clk);
        chk("score_saturated", BW'(score), BW'(16'hFFFF));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
